irq_responder: RTL
==================

// Module: irq_responder
// PURPOSE
//  CPU-side responder for the interrupt controller's IRQ/IACK/isr_addr interface.
//  - Samples IRQ at instruction boundaries and latches the ISR address and return PC.
//  - Redirects the fetch PC to the ISR and issues a one-cycle IACK so the controller
//    clears the serviced status bit.
//  - Masks further interrupts until return-from-interrupt (eret), then redirects to
//    the saved PC. Sits between the intc and the processor fetch stage.
// PARAMETERS
//  ADDR_W   32  width of PC / ISR address
//  HOLDOFF  2   cycles after return before IRQ is sampled again (1..15)
//  CNT_W    16  width of saturating serviced-interrupt counter
// PORTS
//  clk            in   1        system clock, rising edge
//  rst            in   1        asynchronous, active-high reset
//  IRQ            in   1        interrupt request from intc
//  isr_addr       in   ADDR_W   ISR vector from intc, valid while IRQ=1
//  gie            in   1        global interrupt enable (software-controlled)
//  boundary       in   1        fetch stage at a safe instruction boundary this cycle
//  pc_next        in   ADDR_W   PC of the next instruction to execute
//  eret           in   1        return-from-interrupt retired (single-cycle pulse)
//  IACK           out  1        acknowledge to intc, one-cycle pulse
//  redirect       out  1        fetch redirect strobe, one-cycle pulse
//  redirect_addr  out  ADDR_W   target PC; valid when redirect=1
//  epc            out  ADDR_W   saved return PC
//  in_isr         out  1        high from TAKE through RETURN inclusive
//  irq_count      out  CNT_W    number of interrupts taken, saturating
// BEHAVIOUR
//  Reset values (async, immediate on rst=1):
//  - Registers: state=IDLE; IACK=0, redirect=0, redirect_addr=0, epc=0, in_isr=0,
//    irq_count=0; holdoff counter=0.
//  States: IDLE, TAKE, ISR, RETURN, HOLD.
//  - IDLE: on a clk edge with IRQ & gie & boundary:
//    - latch tgt<=isr_addr and epc<=pc_next;
//    - next state TAKE.
//    Otherwise stay. eret in IDLE is ignored.
//  - TAKE (exactly 1 cycle):
//    - IACK=1, redirect=1, redirect_addr=tgt, in_isr=1;
//    - irq_count+=1, saturating at all-ones;
//    - next state ISR.
//    Commitment is final: IRQ dropping after the sample edge does not cancel TAKE.
//  - ISR: in_isr=1; IRQ ignored (no nesting); gie ignored.
//    - eret=1 on an edge -> RETURN.
//    - eret and IRQ together: eret wins; IRQ stays pending at intc and is
//      re-sampled after HOLD.
//  - RETURN (1 cycle):
//    - redirect=1, redirect_addr=epc, in_isr=1;
//    - load holdoff counter=HOLDOFF;
//    - next state HOLD.
//  - HOLD: in_isr=0; decrement counter each cycle; at 0 -> IDLE.
//    - IRQ is not sampled in HOLD, so the intc status clear has propagated.
//  Timing and register rules:
//  - Latency: IRQ sample edge -> IACK/redirect high in the following cycle (1 cycle).
//  - Latency: eret edge -> return redirect in the following cycle.
//  - IACK and redirect are registered outputs and are never high for 2 consecutive
//    cycles.
//  - redirect_addr holds its last value when redirect=0.
//  - epc is stable from TAKE until the next IDLE sample edge.
//  - Reset mid-operation (any state): immediate return to reset values. A pending
//    intc request is re-taken after reset deasserts.
//  - boundary=0 while IRQ=1: wait in IDLE indefinitely; no IACK is issued.
// TESTING
//  1. Basic take: IRQ=1, isr_addr=0x0000_0100, pc_next=0x0000_0040,
//     gie=1, boundary=1 -> next cycle IACK=1, redirect=1,
//     redirect_addr=0x100, epc=0x40, irq_count=1.
//  2. Return: in ISR, pulse eret -> next cycle redirect=1, redirect_addr=0x40;
//     IRQ held high is not re-taken until HOLDOFF=2 cycles after RETURN.
//  3. Masking: gie=0 or boundary=0 with IRQ=1 for 10 cycles -> IACK=0, redirect=0
//     throughout; raising boundary -> take on the next edge.
//  4. No nesting: second IRQ (isr_addr=0x200) during ISR -> no IACK until after
//     eret+HOLD; then taken with redirect_addr=0x200.
//  5. Reset mid-ISR: rst=1 while in ISR -> in_isr, epc, irq_count all 0
//     immediately; no redirect to the old epc.
//  6. Saturation: CNT_W=2, take 5 interrupts -> irq_count stays at 3.

Source files
------------

// File: rtl/irq_responder.sv
// CPU-side interrupt responder: samples IRQ at instruction boundaries, redirects
// fetch to the ISR with a one-cycle IACK, and returns to the saved PC on eret.
module irq_responder #(
  parameter int ADDR_W  = 32,
  parameter int HOLDOFF = 2,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              IRQ,
  input  logic [ADDR_W-1:0] isr_addr,
  input  logic              gie,
  input  logic              boundary,
  input  logic [ADDR_W-1:0] pc_next,
  input  logic              eret,
  output logic              IACK,
  output logic              redirect,
  output logic [ADDR_W-1:0] redirect_addr,
  output logic [ADDR_W-1:0] epc,
  output logic              in_isr,
  output logic [CNT_W-1:0]  irq_count
);

  typedef enum logic [2:0] {
    IDLE,
    TAKE,
    ISR,
    RETURN,
    HOLD
  } state_t;

  localparam logic [3:0] HOLD_LOAD = 4'(HOLDOFF);

  state_t     state;
  logic [3:0] hold_cnt;
  logic       take_irq;

  assign take_irq = IRQ && gie && boundary;

  // Outputs are registered, so each is set on the edge that enters the state
  // in which it must be visible.
  // NOTE: sequential state uses non-blocking assignments only, so every branch
  // reads the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      hold_cnt      <= '0;
      IACK          <= 1'b0;
      redirect      <= 1'b0;
      redirect_addr <= '0;
      epc           <= '0;
      in_isr        <= 1'b0;
      irq_count     <= '0;
    end else begin
      IACK     <= 1'b0;
      redirect <= 1'b0;
      case (state)
        IDLE: begin
          if (take_irq) begin
            state         <= TAKE;
            IACK          <= 1'b1;
            redirect      <= 1'b1;
            redirect_addr <= isr_addr;
            epc           <= pc_next;
            in_isr        <= 1'b1;
            if (irq_count != '1) irq_count <= irq_count + CNT_W'(1);
          end
        end
        TAKE: state <= ISR;
        ISR: begin
          // IRQ and gie are ignored here; a request raised now stays pending
          // at the controller until HOLD has elapsed.
          if (eret) begin
            state         <= RETURN;
            redirect      <= 1'b1;
            redirect_addr <= epc;
          end
        end
        RETURN: begin
          state    <= HOLD;
          hold_cnt <= HOLD_LOAD;
          in_isr   <= 1'b0;
        end
        HOLD: begin
          if (hold_cnt <= 4'd1) begin
            state    <= IDLE;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
